as5600_i2c_target: RTL

- Synthesizable I2C target that emulates the AS5600 magnetic encoder's angle registers.
- Lets the pwm_ctrl I2C master, and the angle loop behind it, be exercised on the bench or in an FPGA loopback without a physical sensor.
- Samples scl/sda with the fast system clock and answers register-pointer writes and angle reads.
- Angle value comes from a model or stimulus on raw_angle; SDA is driven as open-drain through sda_pull_low.

---
 rtl/as5600_pkg.sv | 24 ++
 rtl/i2c_bus_sync.sv | 45 ++++
 rtl/as5600_i2c_target.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/as5600_pkg.sv
// Shared constants and FSM encoding for the AS5600 angle-register I2C target.
package as5600_pkg;

  localparam logic [6:0] AS5600_ADDR   = 7'h36;

  localparam logic [7:0] REG_STATUS    = 8'h0B;
  localparam logic [7:0] REG_RAW_ANG_H = 8'h0C;
  localparam logic [7:0] REG_RAW_ANG_L = 8'h0D;
  localparam logic [7:0] REG_ANG_H     = 8'h0E;
  localparam logic [7:0] REG_ANG_L     = 8'h0F;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } as5600_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes scl/sda into the system clock domain and derives
// scl edge pulses plus START/STOP condition pulses.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic scl,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_d;
  logic                   sda_d;

  // Idle bus is high on both lines, so reset the chains high to avoid false edges.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & sda_d & ~sda_s;
  assign stop_det  = scl_s & ~sda_d & sda_s;

endmodule

// File: rtl/as5600_i2c_target.sv
// I2C target emulating the AS5600 angle registers; SDA is open-drain via sda_pull_low.
// Define AS5600_TARGET_STATUS_EN to add the magnet status inputs and register 0x0B.
module as5600_i2c_target
  import as5600_pkg::*;
#(
  parameter logic [6:0]  I2C_ADDR    = AS5600_ADDR,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_pull_low,
  input  logic [11:0] raw_angle,
`ifdef AS5600_TARGET_STATUS_EN
  input  logic        magnet_detect,
  input  logic        magnet_weak,
  input  logic        magnet_strong,
`endif
  output logic        busy,
  output logic        snap_strobe,
  output logic        nack_seen
);

  logic          sda_s;
  logic          scl_rise;
  logic          scl_fall;
  logic          start_det;
  logic          stop_det;

  as5600_state_t state;
  logic [2:0]    bit_cnt;
  logic [6:0]    shift_reg;
  logic [7:0]    rx_byte;
  logic [7:0]    pointer;
  logic [7:0]    tx_byte;
  logic [7:0]    rd_byte;
  logic [11:0]   shadow;
  logic          rw;
  logic          ack_phase;
  logic          ack_done;
`ifdef AS5600_TARGET_STATUS_EN
  logic [2:0]    status_shadow;
`endif

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_sync (
    .clock     (clock),
    .reset_n   (reset_n),
    .scl       (scl),
    .sda_in    (sda_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign rx_byte = {shift_reg, sda_s};

  always_comb begin
    rd_byte = '0;
    case (pointer)
      REG_RAW_ANG_H, REG_ANG_H: rd_byte = {4'h0, shadow[11:8]};
      REG_RAW_ANG_L, REG_ANG_L: rd_byte = shadow[7:0];
`ifdef AS5600_TARGET_STATUS_EN
      REG_STATUS:               rd_byte = {2'b00, status_shadow, 3'b000};
`endif
      default:                  rd_byte = '0;
    endcase
  end

  // Every ACK slot spans two scl falls: the first starts driving the ACK,
  // ack_done is set by the rise in between, the second ends the slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      pointer       <= '0;
      tx_byte       <= '0;
      shadow        <= '0;
      rw            <= 1'b0;
      ack_phase     <= 1'b0;
      ack_done      <= 1'b0;
      sda_pull_low  <= 1'b0;
      busy          <= 1'b0;
      snap_strobe   <= 1'b0;
      nack_seen     <= 1'b0;
`ifdef AS5600_TARGET_STATUS_EN
      status_shadow <= '0;
`endif
    end else begin
      snap_strobe <= 1'b0;
      nack_seen   <= 1'b0;
      if (stop_det) begin
        state        <= ST_IDLE;
        busy         <= 1'b0;
        sda_pull_low <= 1'b0;
      end else if (start_det) begin
        state        <= ST_ADDR;
        bit_cnt      <= '0;
        ack_phase    <= 1'b0;
        ack_done     <= 1'b0;
        sda_pull_low <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_IGNORE: sda_pull_low <= 1'b0;

          ST_ADDR: begin
            if (scl_rise) begin
              shift_reg <= rx_byte[6:0];
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (rx_byte[7:1] == I2C_ADDR) begin
                  state    <= ST_ADDR_ACK;
                  busy     <= 1'b1;
                  rw       <= rx_byte[0];
                  ack_done <= 1'b0;
                end else begin
                  state <= ST_IGNORE;
                  busy  <= 1'b0;
                end
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_rise) begin
              ack_done <= 1'b1;
            end else if (scl_fall) begin
              if (!ack_done) begin
                sda_pull_low <= 1'b1;
                if (rw) begin
                  shadow        <= raw_angle;
                  snap_strobe   <= 1'b1;
`ifdef AS5600_TARGET_STATUS_EN
                  status_shadow <= {magnet_detect, magnet_weak, magnet_strong};
`endif
                end
              end else begin
                ack_done <= 1'b0;
                bit_cnt  <= '0;
                if (rw) begin
                  state        <= ST_RD_DATA;
                  tx_byte      <= rd_byte;
                  sda_pull_low <= ~rd_byte[7];
                end else begin
                  state        <= ST_WR_PTR;
                  sda_pull_low <= 1'b0;
                end
              end
            end
          end

          ST_WR_PTR: begin
            if (scl_rise) begin
              shift_reg <= rx_byte[6:0];
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                pointer  <= rx_byte;
                state    <= ST_PTR_ACK;
                ack_done <= 1'b0;
              end
            end
          end

          ST_PTR_ACK: begin
            if (scl_rise) begin
              ack_done <= 1'b1;
            end else if (scl_fall) begin
              if (!ack_done) begin
                sda_pull_low <= 1'b1;
              end else begin
                sda_pull_low <= 1'b0;
                state        <= ST_WR_DATA;
                ack_phase    <= 1'b0;
                ack_done     <= 1'b0;
                bit_cnt      <= '0;
              end
            end
          end

          ST_WR_DATA: begin
            if (!ack_phase) begin
              if (scl_rise) begin
                shift_reg <= rx_byte[6:0];
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  ack_phase <= 1'b1;
                  ack_done  <= 1'b0;
                  pointer   <= pointer + 8'd1;
                end
              end
            end else if (scl_rise) begin
              ack_done <= 1'b1;
            end else if (scl_fall) begin
              if (!ack_done) begin
                sda_pull_low <= 1'b1;
              end else begin
                sda_pull_low <= 1'b0;
                ack_phase    <= 1'b0;
                ack_done     <= 1'b0;
              end
            end
          end

          ST_RD_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state    <= ST_RD_ACK;
                ack_done <= 1'b0;
              end
            end else if (scl_fall) begin
              tx_byte      <= {tx_byte[6:0], 1'b0};
              sda_pull_low <= ~tx_byte[6];
            end
          end

          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_s) begin
                nack_seen <= 1'b1;
                state     <= ST_IGNORE;
              end else begin
                pointer  <= pointer + 8'd1;
                ack_done <= 1'b1;
              end
            end else if (scl_fall) begin
              if (!ack_done) begin
                sda_pull_low <= 1'b0;
              end else begin
                state        <= ST_RD_DATA;
                tx_byte      <= rd_byte;
                sda_pull_low <= ~rd_byte[7];
                bit_cnt      <= '0;
                ack_done     <= 1'b0;
              end
            end
          end

          default: begin
            state        <= ST_IDLE;
            sda_pull_low <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
